// File: rtl/button_pkg.sv
// Shared types for the button gesture classifier: FSM state encoding and
// millisecond counter width.
package button_pkg;

    localparam int MS_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_HELD   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } btn_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick_o is high for the last cycle of every
// CLK_FREQ*1000-cycle period; clr_i restarts the period from zero.
module ms_tick_gen #(
    parameter int CLK_FREQ = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int DIV = CLK_FREQ * 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick_o = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clr_i || tick_o) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into press/release/short/long/double-click
// pulses. Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_classifier
    import button_pkg::*;
#(
    parameter int CLK_FREQ  = 50,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_db,
    output logic press_p,
    output logic release_p,
    output logic short_p,
    output logic long_p,
    output logic dclick_p,
    output logic repeat_p
);

    if (LONG_MS < 1 || LONG_MS > 65534 || DCLICK_MS < 1 || DCLICK_MS > 65534 ||
        REPEAT_MS < 1 || REPEAT_MS > 65534) begin : g_bad_params
        $error("button_event_classifier: *_MS parameters must be in 1..65534");
    end

    btn_state_e          state_q, state_d;
    logic                pb_prev_q;
    logic [MS_CNT_W-1:0] ms_cnt_q;
    logic                ms_tick;
    logic                clr;
    logic                rise, fall;
    logic                long_hit, dclick_hit;
    logic                press_q, release_q, short_q, long_q, dclick_q;
    logic                short_d, long_d, dclick_d;

    assign rise = pb_db & ~pb_prev_q;
    assign fall = ~pb_db & pb_prev_q;

    // Thresholds fire on the tick that moves ms_cnt onto the limit, so an event
    // lands exactly N ms after the transition that cleared the timer.
    assign long_hit   = ms_tick && (ms_cnt_q == MS_CNT_W'(LONG_MS - 1));
    assign dclick_hit = ms_tick && (ms_cnt_q == MS_CNT_W'(DCLICK_MS - 1));

`ifdef BTN_AUTOREPEAT_EN
    logic rpt_hit;
    logic repeat_q;
    assign rpt_hit = (state_q == ST_HELD) && !fall && ms_tick &&
                     (ms_cnt_q == MS_CNT_W'(REPEAT_MS - 1));
    assign clr      = (state_d != state_q) || rpt_hit;
    assign repeat_p = repeat_q;
`else
    assign clr      = (state_d != state_q);
    assign repeat_p = 1'b0;
`endif

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .tick_o (ms_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pb_prev_q <= 1'b0;
            ms_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dclick_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pb_prev_q <= pb_db;
            if (clr) begin
                ms_cnt_q <= '0;
            end else if (ms_tick && (ms_cnt_q != '1)) begin
                ms_cnt_q <= ms_cnt_q + MS_CNT_W'(1);
            end
            press_q   <= rise;
            release_q <= fall;
            short_q   <= short_d;
            long_q    <= long_d;
            dclick_q  <= dclick_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= rpt_hit;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rise) state_d = ST_PRESS;
            ST_PRESS: begin
                if (long_hit)  state_d = fall ? ST_IDLE : ST_HELD;
                else if (fall) state_d = ST_GAP;
            end
            ST_HELD:   if (fall) state_d = ST_IDLE;
            ST_GAP: begin
                if (rise)            state_d = ST_PRESS2;
                else if (dclick_hit) state_d = ST_IDLE;
            end
            ST_PRESS2: if (fall) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A second press arriving on the window-expiry cycle counts as a double click.
    always_comb begin
        long_d   = (state_q == ST_PRESS) && long_hit;
        dclick_d = (state_q == ST_GAP) && rise;
        short_d  = (state_q == ST_GAP) && !rise && dclick_hit;
    end

    assign press_p   = press_q;
    assign release_p = release_q;
    assign short_p   = short_q;
    assign long_p    = long_q;
    assign dclick_p  = dclick_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with 1 ms = 1000 cycles.
module tb_button_event_classifier;

    localparam int CLK_FREQ  = 1;
    localparam int LONG_MS   = 10;
    localparam int DCLICK_MS = 4;
    localparam int REPEAT_MS = 3;
    localparam int MS        = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_db = 1'b0;
    logic press_p, release_p, short_p, long_p, dclick_p, repeat_p;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_dclick = 0, n_rep = 0;
    int t_press = 0, t_rel = 0, t_short = 0, t_long = 0, t_dclick = 0;
    int t_rep[$];

    always #5 clk = ~clk;

    button_event_classifier #(
        .CLK_FREQ(CLK_FREQ), .LONG_MS(LONG_MS), .DCLICK_MS(DCLICK_MS), .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb_db(pb_db),
        .press_p(press_p), .release_p(release_p), .short_p(short_p),
        .long_p(long_p), .dclick_p(dclick_p), .repeat_p(repeat_p)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (press_p)   begin n_press++;  t_press  = cyc; end
        if (release_p) begin n_rel++;    t_rel    = cyc; end
        if (short_p)   begin n_short++;  t_short  = cyc; end
        if (long_p)    begin n_long++;   t_long   = cyc; end
        if (dclick_p)  begin n_dclick++; t_dclick = cyc; end
        if (repeat_p)  begin n_rep++;    t_rep.push_back(cyc); end
    end

    task automatic drive(input logic val, input int ncyc);
        pb_db = val;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pb_db = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({press_p, release_p, short_p, long_p, dclick_p, repeat_p} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {press_p, release_p, short_p, long_p, dclick_p, repeat_p});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_short();
        int bp = n_press, br = n_rel, bs = n_short, bl = n_long, bd = n_dclick;
        drive(1'b1, 2000);
        drive(1'b0, 4500);
        #1;
        checks++; if (n_press - bp !== 1) begin errors++; $display("FAIL short_press_cnt: got %0d expected 1", n_press - bp); end
        checks++; if (n_rel - br !== 1) begin errors++; $display("FAIL short_rel_cnt: got %0d expected 1", n_rel - br); end
        checks++; if (n_short - bs !== 1) begin errors++; $display("FAIL short_cnt: got %0d expected 1", n_short - bs); end
        checks++; if (t_short - t_rel !== DCLICK_MS * MS) begin errors++; $display("FAIL short_latency: got %0d expected %0d", t_short - t_rel, DCLICK_MS * MS); end
        checks++; if (t_rel - t_press !== 2000) begin errors++; $display("FAIL short_hold: got %0d expected 2000", t_rel - t_press); end
        checks++; if ((n_long - bl) + (n_dclick - bd) !== 0) begin errors++; $display("FAIL short_no_long_dclick: got %0d expected 0", (n_long - bl) + (n_dclick - bd)); end
        $display("test_short done: short at +%0d after release", t_short - t_rel);
    endtask

    task automatic test_long();
        int br = n_rel, bs = n_short, bl = n_long, bd = n_dclick;
        drive(1'b1, 11000);
        drive(1'b0, 4500);
        #1;
        checks++; if (n_long - bl !== 1) begin errors++; $display("FAIL long_cnt: got %0d expected 1", n_long - bl); end
        checks++; if (t_long - t_press !== LONG_MS * MS) begin errors++; $display("FAIL long_latency: got %0d expected %0d", t_long - t_press, LONG_MS * MS); end
        checks++; if (n_rel - br !== 1) begin errors++; $display("FAIL long_rel_cnt: got %0d expected 1", n_rel - br); end
        checks++; if ((n_short - bs) + (n_dclick - bd) !== 0) begin errors++; $display("FAIL long_no_short: got %0d expected 0", (n_short - bs) + (n_dclick - bd)); end
        $display("test_long done: long at +%0d after press", t_long - t_press);
    endtask

    task automatic test_dclick();
        int bp = n_press, bs = n_short, bl = n_long, bd = n_dclick;
        drive(1'b1, 1000);
        drive(1'b0, 2000);
        drive(1'b1, 1000);
        drive(1'b0, 4500);
        #1;
        checks++; if (n_dclick - bd !== 1) begin errors++; $display("FAIL dclick_cnt: got %0d expected 1", n_dclick - bd); end
        checks++; if (t_dclick !== t_press) begin errors++; $display("FAIL dclick_time: got %0d expected %0d", t_dclick, t_press); end
        checks++; if (n_press - bp !== 2) begin errors++; $display("FAIL dclick_press_cnt: got %0d expected 2", n_press - bp); end
        checks++; if ((n_short - bs) + (n_long - bl) !== 0) begin errors++; $display("FAIL dclick_no_short: got %0d expected 0", (n_short - bs) + (n_long - bl)); end
        $display("test_dclick done");
    endtask

    task automatic test_boundaries();
        int br = n_rel, bs = n_short, bl = n_long, bd = n_dclick;
        // release lands on the exact long threshold cycle
        drive(1'b1, LONG_MS * MS);
        drive(1'b0, 100);
        #1;
        checks++; if (n_long - bl !== 1) begin errors++; $display("FAIL edge_long_cnt: got %0d expected 1", n_long - bl); end
        checks++; if (t_long !== t_rel || n_rel - br !== 1) begin errors++; $display("FAIL edge_long_rel: got long@%0d rel@%0d expected equal", t_long, t_rel); end
        drive(1'b1, 1000);
        drive(1'b0, 4500);
        #1;
        checks++; if (n_short - bs !== 1) begin errors++; $display("FAIL edge_long_idle: got shorts %0d expected 1", n_short - bs); end
        checks++; if (n_dclick - bd !== 0) begin errors++; $display("FAIL edge_long_no_dclick: got %0d expected 0", n_dclick - bd); end
        // second press lands on the exact double-click expiry cycle
        bs = n_short;
        drive(1'b1, 1000);
        drive(1'b0, DCLICK_MS * MS);
        drive(1'b1, 1000);
        drive(1'b0, 4500);
        #1;
        checks++; if (n_dclick - bd !== 1) begin errors++; $display("FAIL edge_dclick_cnt: got %0d expected 1", n_dclick - bd); end
        checks++; if (n_short - bs !== 0) begin errors++; $display("FAIL edge_dclick_no_short: got %0d expected 0", n_short - bs); end
        $display("test_boundaries done");
    endtask

    task automatic test_reset_in_gap();
        int bp = n_press, bs = n_short, bd = n_dclick;
        drive(1'b1, 1000);
        drive(1'b0, 1000);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if ({press_p, release_p, short_p, long_p, dclick_p, repeat_p} !== 6'b0) begin
            errors++;
            $display("FAIL gap_reset_outputs: got %b expected 000000",
                     {press_p, release_p, short_p, long_p, dclick_p, repeat_p});
        end
        rst_n = 1'b1;
        drive(1'b0, 100);
        drive(1'b1, 1000);
        drive(1'b0, 4500);
        #1;
        checks++; if (n_short - bs !== 1) begin errors++; $display("FAIL gap_reset_short_cnt: got %0d expected 1", n_short - bs); end
        checks++; if (t_short - t_rel !== DCLICK_MS * MS) begin errors++; $display("FAIL gap_reset_latency: got %0d expected %0d", t_short - t_rel, DCLICK_MS * MS); end
        checks++; if (n_dclick - bd !== 0 || n_press - bp !== 2) begin errors++; $display("FAIL gap_reset_fresh: got dclick %0d press %0d expected 0 2", n_dclick - bd, n_press - bp); end
        $display("test_reset_in_gap done");
    endtask

    task automatic test_repeat();
        int bq = n_rep;
        int bt = t_rep.size();
        drive(1'b1, 20000);
        drive(1'b0, 500);
        #1;
`ifdef BTN_AUTOREPEAT_EN
        checks++; if (n_rep - bq !== 3) begin errors++; $display("FAIL repeat_cnt: got %0d expected 3", n_rep - bq); end
        if (t_rep.size() >= bt + 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (t_rep[bt + i] - t_long !== REPEAT_MS * MS * (i + 1)) begin
                    errors++;
                    $display("FAIL repeat_time%0d: got %0d expected %0d", i, t_rep[bt + i] - t_long, REPEAT_MS * MS * (i + 1));
                end
            end
        end
`else
        checks++; if (n_rep - bq !== 0 || t_rep.size() !== bt) begin errors++; $display("FAIL repeat_off: got %0d expected 0", n_rep - bq); end
`endif
        $display("test_repeat done: %0d repeat pulses", n_rep - bq);
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_dclick();
        test_boundaries();
        test_reset_in_gap();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
